// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// MSB first, with a dedicated single-cycle path for a zero divisor.
module divider #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  dvd_q, dvd_d;
  logic [n-1:0]  dsr_q, dsr_d;
  logic [n-1:0]  rem_q, rem_d;
  logic [n-1:0]  quo_q, quo_d;
  logic [n-1:0]  quotient_q, quotient_d;
  logic [n-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [n:0]    r_shift;
  logic [n:0]    diff;
  logic [n-1:0]  rem_step;
  logic [n-1:0]  quo_step;

  // One restoring step; a set borrow bit means the trial subtraction failed.
  always_comb begin
    r_shift  = {rem_q, dvd_q[n-1]};
    diff     = r_shift - {1'b0, dsr_q};
    rem_step = diff[n] ? r_shift[n-1:0] : diff[n-1:0];
    quo_step = {quo_q[n-2:0], ~diff[n]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
          dbz_d   = 1'b0;
          cnt_d   = CW'(n);
          state_d = (divisor == '0) ? S_ZERO : S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = rem_step;
        quo_d = quo_step;
        dvd_d = {dvd_q[n-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        // Visible results change only here, so no partial quotient ever leaks out.
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          quotient_d  = quo_step;
          remainder_d = rem_step;
        end
      end
      S_ZERO: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        done_d      = 1'b1;
        quotient_d  = '1;
        remainder_d = dvd_q;
        dbz_d       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
